pcie_us_cfg_mgmt_resp: RTL and testbench
========================================

Name: pcie_us_cfg_mgmt_resp

Overview:
- Responder (hard-IP side) of the UltraScale PCIe cfg_mgmt interface.
- Accepts dword read/write requests from a cfg_mgmt initiator and backs them with a small register file.
- Returns read data and a one-cycle done strobe after a fixed latency.
- Used in simulation and in loopback/bridge builds where the example core's config-management port is driven without the hard IP.

Parameters:
- ADDR_WIDTH, 6, number of backed dword address bits (2**ADDR_WIDTH dwords, function 0 only).
- LATENCY, 4, cycles from request acceptance to done strobe; legal range 1..15.
- ID_VALUE, 32'h9038_10ee, read-only contents of dword 0 (device/vendor ID).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cfg_mgmt_addr  in  10  dword address
- cfg_mgmt_function_number  in  8  target function
- cfg_mgmt_write  in  1  write request, level, held until done
- cfg_mgmt_write_data  in  32  write data
- cfg_mgmt_byte_enable  in  4  per-byte write enable
- cfg_mgmt_read  in  1  read request, level, held until done
- cfg_mgmt_read_data  out  32  read data, valid in the done cycle
- cfg_mgmt_read_write_done  out  1  one-cycle completion strobe
- status_busy  out  1  high in BUSY and DONE
- status_protocol_error  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync release):
  - read_data=0, done=0, status_busy=0, status_protocol_error=0, state=IDLE.
  - All storage dwords cleared to 0; dword 0 reads ID_VALUE permanently.
- FSM states: IDLE, BUSY, DONE, HOLD.
- IDLE:
  - On read|write, latch addr, function, write_data, byte_enable and op (write if write=1, else read).
  - Load counter=LATENCY-1, go to BUSY.
  - read&write both high: treat as write, set status_protocol_error.
- BUSY:
  - Decrement counter each cycle; at counter==0 go to DONE.
  - If read and write both deassert while in BUSY: abort to IDLE, no done, no storage update, set status_protocol_error.
  - Input changes other than deassertion are ignored; latched values are used.
- DONE (exactly one cycle):
  - done=1.
  - Write: storage updated per byte where byte_enable[i]=1; read_data unchanged.
  - Read: read_data = storage value.
  - Next state HOLD.
- HOLD (one cycle): requests ignored, so the initiator's still-asserted level (deasserted the cycle after done) does not re-trigger. Then go to IDLE.
- Latency: done asserts exactly LATENCY+1 cycles after the first cycle read/write is seen high in IDLE. Back-to-back minimum spacing is LATENCY+3 cycles.
- Address decode:
  - Backed only if function_number==0 and addr < 2**ADDR_WIDTH.
  - Unbacked reads return 0; unbacked writes are dropped.
  - Done is always generated for unbacked accesses.
  - Writes to dword 0 are dropped; done is still generated.
- read_data holds its value between done strobes.
- status_protocol_error clears only on rst.
- Reset mid-operation: immediate return to IDLE, all outputs and storage to reset values, no done.

Optional Feature:
- Macro: CFG_MGMT_RESP_RANDOM_LATENCY_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) is seeded 8'hA5 on reset and advances once per accepted request.
  - Extra delay of lfsr[2:0] cycles is added to LATENCY for that request, using the value before advancing.
  - Total latency range is LATENCY..LATENCY+7; abort rules still apply during the extra cycles.
- When undefined: latency is exactly LATENCY; no LFSR logic is built.

Test Plan:
- Reset, then read addr 0 func 0 (LATENCY=4) -> done pulses 5 cycles after read rises, read_data=32'h9038_10ee, single-cycle done.
- Write addr 5 data 32'hDEAD_BEEF be=4'b0101, then read addr 5 -> read_data=32'h00AD_00EF; error flag stays 0.
- Write addr 0 with 32'h1234_5678 be=4'hF, then read addr 0 -> done generated for both; read returns ID_VALUE.
- Read addr 70 (beyond 64 dwords) and read addr 3 func 1 -> read_data=0 for both, done asserted for each.
- Assert read and write together at addr 2 with data 32'h1 -> treated as write, status_protocol_error=1; subsequent read addr 2 returns 1.
- Deassert write 2 cycles into BUSY -> no done, addr untouched; error flag set. Assert rst mid-BUSY on a later request -> done never pulses, read_data=0.

Source files
------------

// File: rtl/pcie_us_cfg_mgmt_resp.sv
// pcie_us_cfg_mgmt_resp
// Hard-IP side responder for the UltraScale PCIe cfg_mgmt port. It backs
// function 0 dword reads/writes with a small register file and completes each
// access with a one-cycle done strobe after a fixed latency. Dword 0 is a
// read-only ID register.
//
// Optional build macro: CFG_MGMT_RESP_RANDOM_LATENCY_EN
//   When defined, an 8-bit LFSR adds 0..7 extra cycles to each access so the
//   initiator gets exercised against variable completion timing.

module pcie_us_cfg_mgmt_resp #(
  parameter int          ADDR_WIDTH = 6,
  parameter int          LATENCY    = 4,
  parameter logic [31:0] ID_VALUE   = 32'h9038_10ee
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  cfg_mgmt_addr,
  input  logic [7:0]  cfg_mgmt_function_number,
  input  logic        cfg_mgmt_write,
  input  logic [31:0] cfg_mgmt_write_data,
  input  logic [3:0]  cfg_mgmt_byte_enable,
  input  logic        cfg_mgmt_read,
  output logic [31:0] cfg_mgmt_read_data,
  output logic        cfg_mgmt_read_write_done,
  output logic        status_busy,
  output logic        status_protocol_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Wide enough for LATENCY-1 (max 14) plus 7 extra random cycles.
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    HOLD
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load;

  logic [9:0]  lat_addr;
  logic [7:0]  lat_func;
  logic [31:0] lat_data;
  logic [3:0]  lat_be;
  logic        lat_write;

  logic [31:0] mem [DEPTH];

  logic                  req_any;
  logic                  req_both;
  logic                  take_req;
  logic                  abort_req;
  logic                  finish_req;
  logic                  backed;
  logic [ADDR_WIDTH-1:0] mem_idx;

  assign req_any    = cfg_mgmt_read | cfg_mgmt_write;
  assign req_both   = cfg_mgmt_read & cfg_mgmt_write;
  assign take_req   = (state == IDLE) && req_any;
  // Dropping both request levels mid-flight abandons the access.
  assign abort_req  = (state == BUSY) && !req_any;
  assign finish_req = (state == BUSY) && req_any && (cnt == '0);

  // Only function 0 inside the backed window maps onto storage.
  assign backed  = (lat_func == 8'd0) && (int'(lat_addr) < DEPTH);
  assign mem_idx = lat_addr[ADDR_WIDTH-1:0];

`ifdef CFG_MGMT_RESP_RANDOM_LATENCY_EN
  logic [7:0] lfsr;

  // LFSR x^8+x^6+x^5+x^4+1 steps once per accepted request; the pre-step value sets the extra delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else if (take_req) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[2:0]);
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the state-decoded done and busy outputs.
  always_comb begin
    state_next               = state;
    cfg_mgmt_read_write_done = 1'b0;
    status_busy              = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        status_busy = 1'b1;
        if (!req_any) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        status_busy              = 1'b1;
        cfg_mgmt_read_write_done = 1'b1;
        state_next               = HOLD;
      end
      HOLD: begin
        // The initiator may still hold its level here; ignore it.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the request at acceptance and count down the latency while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_func  <= '0;
      lat_data  <= '0;
      lat_be    <= '0;
      lat_write <= 1'b0;
    end else if (take_req) begin
      cnt       <= cnt_load;
      lat_addr  <= cfg_mgmt_addr;
      lat_func  <= cfg_mgmt_function_number;
      lat_data  <= cfg_mgmt_write_data;
      lat_be    <= cfg_mgmt_byte_enable;
      lat_write <= cfg_mgmt_write;
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Register file: byte-enabled writes land as the access completes; dword 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (finish_req && lat_write && backed && (mem_idx != '0)) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) begin
          mem[mem_idx][8*b +: 8] <= lat_data[8*b +: 8];
        end
      end
    end
  end

  // Read data is loaded for the done cycle of a read and otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_mgmt_read_data <= '0;
    end else if (finish_req && !lat_write) begin
      if (!backed) begin
        cfg_mgmt_read_data <= '0;
      end else if (mem_idx == '0) begin
        cfg_mgmt_read_data <= ID_VALUE;
      end else begin
        cfg_mgmt_read_data <= mem[mem_idx];
      end
    end
  end

  // Sticky flag for simultaneous read+write or a request dropped before done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_protocol_error <= 1'b0;
    end else if ((take_req && req_both) || abort_req) begin
      status_protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_resp.sv
// tb_pcie_us_cfg_mgmt_resp
// Scoreboard bench for pcie_us_cfg_mgmt_resp. Each access pushes its expected
// read_data into a queue; a monitor pops and compares on every done strobe.
// Honors CFG_MGMT_RESP_RANDOM_LATENCY_EN with its own LFSR model.

module tb_pcie_us_cfg_mgmt_resp;

  localparam int          LAT    = 4;
  localparam int          DEPTH  = 64;
  localparam logic [31:0] ID_VAL = 32'h9038_10ee;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cfg_mgmt_addr;
  logic [7:0]  cfg_mgmt_function_number;
  logic        cfg_mgmt_write;
  logic [31:0] cfg_mgmt_write_data;
  logic [3:0]  cfg_mgmt_byte_enable;
  logic        cfg_mgmt_read;
  logic [31:0] cfg_mgmt_read_data;
  logic        cfg_mgmt_read_write_done;
  logic        status_busy;
  logic        status_protocol_error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_q [$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rd;
  logic [31:0] mon_exp;
`ifdef CFG_MGMT_RESP_RANDOM_LATENCY_EN
  logic [7:0]  tb_lfsr;
`endif

  pcie_us_cfg_mgmt_resp #(
    .ADDR_WIDTH(6),
    .LATENCY   (LAT),
    .ID_VALUE  (ID_VAL)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .cfg_mgmt_addr           (cfg_mgmt_addr),
    .cfg_mgmt_function_number(cfg_mgmt_function_number),
    .cfg_mgmt_write          (cfg_mgmt_write),
    .cfg_mgmt_write_data     (cfg_mgmt_write_data),
    .cfg_mgmt_byte_enable    (cfg_mgmt_byte_enable),
    .cfg_mgmt_read           (cfg_mgmt_read),
    .cfg_mgmt_read_data      (cfg_mgmt_read_data),
    .cfg_mgmt_read_write_done(cfg_mgmt_read_write_done),
    .status_busy             (status_busy),
    .status_protocol_error   (status_protocol_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  function automatic int nextExtra();
`ifdef CFG_MGMT_RESP_RANDOM_LATENCY_EN
    int e;
    e = int'(tb_lfsr[2:0]);
    tb_lfsr = {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
    return e;
`else
    return 0;
`endif
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
    end
    model_rd = '0;
    sb_q.delete();
`ifdef CFG_MGMT_RESP_RANDOM_LATENCY_EN
    tb_lfsr = 8'hA5;
`endif
  endtask

  task automatic dropRequest();
    cfg_mgmt_read  = 1'b0;
    cfg_mgmt_write = 1'b0;
  endtask

  task automatic driveRequest(input logic wr, input logic rd, input logic [9:0] addr,
                              input logic [7:0] func, input logic [31:0] data, input logic [3:0] be);
    cfg_mgmt_write           = wr;
    cfg_mgmt_read            = rd;
    cfg_mgmt_addr            = addr;
    cfg_mgmt_function_number = func;
    cfg_mgmt_write_data      = data;
    cfg_mgmt_byte_enable     = be;
  endtask

  // Full access: model it, push the expectation, drive it, wait for done.
  // Returns in the HOLD cycle with the request level still asserted.
  task automatic applyStimulus(input string tag, input logic wr, input logic rd, input logic [9:0] addr,
                               input logic [7:0] func, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] exp;
    int          idx;
    int          extra;
    int          cycles;
    bit          seen;
    bit          is_backed;
    idx       = int'(addr);
    is_backed = (func == 8'd0) && (idx < DEPTH);
    if (wr) begin
      if (is_backed && idx != 0) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
      end
      exp = model_rd;
    end else begin
      exp      = !is_backed ? 32'd0 : (idx == 0 ? ID_VAL : model_mem[idx]);
      model_rd = exp;
    end
    extra = nextExtra();
    sb_q.push_back(exp);
    @(negedge clk);
    driveRequest(wr, rd, addr, func, data, be);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 64) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) checkOutput({tag, "_busy_start"}, 32'(status_busy), 32'd1);
      if (cfg_mgmt_read_write_done) seen = 1'b1;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(LAT + 1 + extra));
    if (!seen) begin
      if (sb_q.size() != 0) void'(sb_q.pop_back());
    end else begin
      checkOutput({tag, "_busy_done"}, 32'(status_busy), 32'd1);
    end
    @(negedge clk);
    checkOutput({tag, "_done_single"}, 32'(cfg_mgmt_read_write_done), 32'd0);
    checkOutput({tag, "_busy_hold"}, 32'(status_busy), 32'd0);
  endtask

  // Write that is abandoned two cycles into BUSY; no done may follow.
  task automatic abortRequest(input string tag, input logic [9:0] addr, input logic [31:0] data);
    int ndone;
    dropRequest();
    void'(nextExtra());
    @(negedge clk);
    driveRequest(1'b1, 1'b0, addr, 8'd0, data, 4'hF);
    repeat (2) @(negedge clk);
    dropRequest();
    ndone = 0;
    repeat (LAT + 12) begin
      @(negedge clk);
      if (cfg_mgmt_read_write_done) ndone++;
    end
    checkOutput({tag, "_no_done"}, 32'(ndone), 32'd0);
    checkOutput({tag, "_busy"}, 32'(status_busy), 32'd0);
  endtask

  // Read that is killed by rst while BUSY.
  task automatic resetMidBusy(input string tag, input logic [9:0] addr);
    int ndone;
    dropRequest();
    void'(nextExtra());
    @(negedge clk);
    driveRequest(1'b0, 1'b1, addr, 8'd0, 32'd0, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dropRequest();
    modelReset();
    #1;
    checkOutput({tag, "_rd_data"}, cfg_mgmt_read_data, 32'd0);
    checkOutput({tag, "_busy"}, 32'(status_busy), 32'd0);
    checkOutput({tag, "_perr"}, 32'(status_protocol_error), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (LAT + 12) begin
      @(negedge clk);
      if (cfg_mgmt_read_write_done) ndone++;
    end
    checkOutput({tag, "_no_done"}, 32'(ndone), 32'd0);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && cfg_mgmt_read_write_done) begin
      checkOutput("done_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        checkOutput("read_data", cfg_mgmt_read_data, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    driveRequest(1'b0, 1'b0, 10'd0, 8'd0, 32'd0, 4'h0);
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_rd_data", cfg_mgmt_read_data, 32'd0);
    checkOutput("rst_done", 32'(cfg_mgmt_read_write_done), 32'd0);
    checkOutput("rst_busy", 32'(status_busy), 32'd0);
    checkOutput("rst_perr", 32'(status_protocol_error), 32'd0);
    rst = 1'b0;

    applyStimulus("rd_id", 1'b0, 1'b1, 10'd0, 8'd0, 32'd0, 4'h0);

    applyStimulus("wr5", 1'b1, 1'b0, 10'd5, 8'd0, 32'hDEAD_BEEF, 4'b0101);
    applyStimulus("rd5", 1'b0, 1'b1, 10'd5, 8'd0, 32'd0, 4'h0);
    checkOutput("perr_after_rw", 32'(status_protocol_error), 32'd0);

    applyStimulus("wr0", 1'b1, 1'b0, 10'd0, 8'd0, 32'h1234_5678, 4'hF);
    applyStimulus("rd0", 1'b0, 1'b1, 10'd0, 8'd0, 32'd0, 4'h0);

    applyStimulus("wr3", 1'b1, 1'b0, 10'd3, 8'd0, 32'hCAFE_0003, 4'hF);
    applyStimulus("wr3_f1", 1'b1, 1'b0, 10'd3, 8'd1, 32'h5555_5555, 4'hF);
    applyStimulus("wr70", 1'b1, 1'b0, 10'd70, 8'd0, 32'h7070_7070, 4'hF);
    applyStimulus("wr63", 1'b1, 1'b0, 10'd63, 8'd0, 32'h6363_6363, 4'b1110);
    applyStimulus("rd70", 1'b0, 1'b1, 10'd70, 8'd0, 32'd0, 4'h0);
    applyStimulus("rd3_f1", 1'b0, 1'b1, 10'd3, 8'd1, 32'd0, 4'h0);
    applyStimulus("rd3", 1'b0, 1'b1, 10'd3, 8'd0, 32'd0, 4'h0);
    applyStimulus("rd6_alias", 1'b0, 1'b1, 10'd6, 8'd0, 32'd0, 4'h0);
    applyStimulus("rd63", 1'b0, 1'b1, 10'd63, 8'd0, 32'd0, 4'h0);
    checkOutput("perr_after_unbacked", 32'(status_protocol_error), 32'd0);

    abortRequest("abort7", 10'd7, 32'hFFFF_FFFF);
    checkOutput("perr_after_abort", 32'(status_protocol_error), 32'd1);
    applyStimulus("rd7", 1'b0, 1'b1, 10'd7, 8'd0, 32'd0, 4'h0);

    dropRequest();
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    @(negedge clk);
    checkOutput("rst2_perr", 32'(status_protocol_error), 32'd0);
    checkOutput("rst2_rd_data", cfg_mgmt_read_data, 32'd0);
    rst = 1'b0;
    applyStimulus("rd5_cleared", 1'b0, 1'b1, 10'd5, 8'd0, 32'd0, 4'h0);

    applyStimulus("rd_id2", 1'b0, 1'b1, 10'd0, 8'd0, 32'd0, 4'h0);
    applyStimulus("both2", 1'b1, 1'b1, 10'd2, 8'd0, 32'h0000_0001, 4'hF);
    checkOutput("perr_after_both", 32'(status_protocol_error), 32'd1);
    applyStimulus("rd2", 1'b0, 1'b1, 10'd2, 8'd0, 32'd0, 4'h0);

    resetMidBusy("rst_busy", 10'd2);
    applyStimulus("rd2_cleared", 1'b0, 1'b1, 10'd2, 8'd0, 32'd0, 4'h0);

    dropRequest();
    repeat (4) @(negedge clk);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
